// File: rtl/quad_decoder.sv
// X4 quadrature decoder: position, windowed speed and illegal-transition count; 3-cycle edge-to-position latency.
// Free-running, no backpressure: oSPEED_VALID is a one-cycle pulse per window and must be taken when it fires.
module quad_decoder #(
  parameter int CLK_Freq    = 50000000,
  parameter int SAMPLE_Freq = 100,
  parameter int POS_WIDTH   = 32,
  parameter int SPD_WIDTH   = 16
) (
  input  logic                        iCLK,
  input  logic                        iRST_N,
  input  logic                        iDATA_A,
  input  logic                        iDATA_B,
  input  logic                        iCLR_POS,
  output logic signed [POS_WIDTH-1:0] oPOSITION,
  output logic signed [SPD_WIDTH-1:0] oSPEED,
  output logic                        oSPEED_VALID,
  output logic                        oDIR,
  output logic [7:0]                  oERR_CNT
);

  localparam int WIN = CLK_Freq / SAMPLE_Freq;
  localparam int WW  = (WIN > 1) ? $clog2(WIN) : 1;
  localparam logic signed [SPD_WIDTH+1:0] ACC_MAX = {2'b00, {SPD_WIDTH{1'b1}}};
  localparam logic signed [SPD_WIDTH+1:0] ACC_MIN = {2'b11, {SPD_WIDTH{1'b0}}};
  localparam logic signed [SPD_WIDTH+1:0] SPD_MAX = {3'b000, {(SPD_WIDTH-1){1'b1}}};
  localparam logic signed [SPD_WIDTH+1:0] SPD_MIN = {3'b111, {(SPD_WIDTH-1){1'b0}}};

  logic                        a_meta_q, a_sync_q, b_meta_q, b_sync_q;
  logic [1:0]                  prev_q;
  logic [1:0]                  prime_q, prime_d;
  logic signed [POS_WIDTH-1:0] pos_q, pos_d;
  logic                        dir_q, dir_d;
  logic [7:0]                  err_q, err_d;
  logic [WW-1:0]               win_q, win_d;
  logic signed [SPD_WIDTH:0]   acc_q, acc_d, acc_sat;
  logic signed [SPD_WIDTH-1:0] spd_q, spd_d, spd_sat;
  logic                        vld_q, vld_d;

  logic [1:0]                  cur_s, cur_idx, prev_idx, diff;
  logic                        primed, fwd, rev, ill, term;
  logic signed [1:0]           step;
  logic signed [SPD_WIDTH+1:0] sum;

  // Map the Gray-coded {A,B} onto a 0..3 phase index so a step is a phase difference.
  assign cur_s    = {a_sync_q, b_sync_q};
  assign cur_idx  = {cur_s[0], cur_s[1] ^ cur_s[0]};
  assign prev_idx = {prev_q[0], prev_q[1] ^ prev_q[0]};
  assign diff     = cur_idx - prev_idx;
  assign primed   = (prime_q == 2'd3);
  assign fwd      = primed && (diff == 2'd1);
  assign rev      = primed && (diff == 2'd3);
  assign ill      = primed && (diff == 2'd2);
  assign step     = fwd ? 2'sd1 : (rev ? -2'sd1 : 2'sd0);
  assign term     = (win_q == WW'(WIN - 1));
  assign sum      = (SPD_WIDTH+2)'(acc_q) + (SPD_WIDTH+2)'(step);

  always_comb begin
    prime_d = primed ? prime_q : prime_q + 2'd1;
    pos_d   = pos_q;
    dir_d   = dir_q;
    err_d   = err_q;
    if (fwd) begin
      pos_d = pos_q + POS_WIDTH'(1);
      dir_d = 1'b1;
    end else if (rev) begin
      pos_d = pos_q - POS_WIDTH'(1);
      dir_d = 1'b0;
    end
    if (iCLR_POS) pos_d = '0;
    if (ill && (err_q != 8'hFF)) err_d = err_q + 8'd1;

    if (sum > ACC_MAX)      acc_sat = ACC_MAX[SPD_WIDTH:0];
    else if (sum < ACC_MIN) acc_sat = ACC_MIN[SPD_WIDTH:0];
    else                    acc_sat = sum[SPD_WIDTH:0];
    if (sum > SPD_MAX)      spd_sat = SPD_MAX[SPD_WIDTH-1:0];
    else if (sum < SPD_MIN) spd_sat = SPD_MIN[SPD_WIDTH-1:0];
    else                    spd_sat = sum[SPD_WIDTH-1:0];

    // The terminal cycle's own step lands in the reported speed, not the next window.
    win_d = term ? '0 : win_q + WW'(1);
    acc_d = term ? '0 : acc_sat;
    spd_d = term ? spd_sat : spd_q;
    vld_d = term;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      a_meta_q <= 1'b0;
      a_sync_q <= 1'b0;
      b_meta_q <= 1'b0;
      b_sync_q <= 1'b0;
      prev_q   <= 2'b00;
      prime_q  <= 2'd0;
      pos_q    <= '0;
      dir_q    <= 1'b0;
      err_q    <= 8'd0;
      win_q    <= '0;
      acc_q    <= '0;
      spd_q    <= '0;
      vld_q    <= 1'b0;
    end else begin
      a_meta_q <= iDATA_A;
      a_sync_q <= a_meta_q;
      b_meta_q <= iDATA_B;
      b_sync_q <= b_meta_q;
      prev_q   <= cur_s;
      prime_q  <= prime_d;
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      err_q    <= err_d;
      win_q    <= win_d;
      acc_q    <= acc_d;
      spd_q    <= spd_d;
      vld_q    <= vld_d;
    end
  end

  assign oPOSITION    = pos_q;
  assign oSPEED       = spd_q;
  assign oSPEED_VALID = vld_q;
  assign oDIR         = dir_q;
  assign oERR_CNT     = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: 10-cycle speed window, 4-bit position to reach the wrap quickly.
module tb_quad_decoder;

  logic        clk = 1'b0;
  logic        rst_n, a, b, clr;
  logic [3:0]  pos;
  logic [15:0] spd;
  logic        vld, dir;
  logic [7:0]  err;
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [3:0]  last_pos;

  always #5 clk = ~clk;

  quad_decoder #(
    .CLK_Freq(1000), .SAMPLE_Freq(100), .POS_WIDTH(4), .SPD_WIDTH(16)
  ) dut (
    .iCLK(clk), .iRST_N(rst_n), .iDATA_A(a), .iDATA_B(b), .iCLR_POS(clr),
    .oPOSITION(pos), .oSPEED(spd), .oSPEED_VALID(vld), .oDIR(dir), .oERR_CNT(err)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a new {A,B}; position must hold for 2 cycles and move on the 3rd.
  task automatic apply(input logic [1:0] ab, input logic [3:0] exp_new, input string tag);
    {a, b} = ab;
    tick(2);
    chk({tag, "_hold"}, 32'(pos), 32'(last_pos));
    tick(1);
    chk({tag, "_step"}, 32'(pos), 32'(exp_new));
    last_pos = exp_new;
    tick(17);
  endtask

  task automatic clear_pos(input string tag);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk(tag, 32'(pos), 32'h0);
    last_pos = 4'h0;
  endtask

  initial begin
    rst_n = 1'b0; a = 1'b1; b = 1'b1; clr = 1'b0; last_pos = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pos", 32'(pos), 32'h0);
    chk("rst_spd", 32'(spd), 32'h0);
    chk("rst_vld", 32'(vld), 32'h0);
    chk("rst_dir", 32'(dir), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    rst_n = 1'b1;
    cyc = 0;

    // Inputs held at 11 through release: priming must swallow the 00->11 seen by the syncs.
    tick(9);
    chk("prime_pos", 32'(pos), 32'h0);
    chk("prime_err", 32'(err), 32'h0);
    chk("win_early", 32'(vld), 32'h0);
    tick(1);
    chk("first_pulse", 32'(vld), 32'h1);
    chk("first_spd", 32'(spd), 32'h0);
    tick(1);
    chk("pulse_width", 32'(vld), 32'h0);

    apply(2'b01, 4'h1, "pre1");
    apply(2'b00, 4'h2, "pre2");
    clear_pos("clr_a");

    apply(2'b10, 4'h1, "fwd1");
    apply(2'b11, 4'h2, "fwd2");
    apply(2'b01, 4'h3, "fwd3");
    apply(2'b00, 4'h4, "fwd4");
    chk("fwd_dir", 32'(dir), 32'h1);

    clear_pos("clr_b");
    apply(2'b01, 4'hF, "rev1");
    apply(2'b11, 4'hE, "rev2");
    apply(2'b10, 4'hD, "rev3");
    apply(2'b00, 4'hC, "rev4");
    apply(2'b01, 4'hB, "rev5");
    apply(2'b11, 4'hA, "rev6");
    chk("rev_dir", 32'(dir), 32'h0);
    apply(2'b10, 4'h9, "rev7");
    apply(2'b00, 4'h8, "rev8");
    apply(2'b01, 4'h7, "wrap");

    apply(2'b00, 4'h8, "pre_ill");
    {a, b} = 2'b11;
    tick(20);
    chk("ill1_err", 32'(err), 32'h1);
    chk("ill1_pos", 32'(pos), 32'h8);
    chk("ill1_dir", 32'(dir), 32'h1);
    {a, b} = 2'b10;
    tick(20);
    chk("rev_after_ill", 32'(pos), 32'h7);
    {a, b} = 2'b01;
    tick(20);
    chk("ill2_err", 32'(err), 32'h2);
    chk("ill2_pos", 32'(pos), 32'h7);
    chk("ill2_dir", 32'(dir), 32'h0);

    for (int i = 0; i < 252; i++) begin
      {a, b} = (i % 2 == 0) ? 2'b10 : 2'b01;
      tick(2);
    end
    tick(4);
    chk("err_254", 32'(err), 32'd254);
    for (int i = 0; i < 48; i++) begin
      {a, b} = (i % 2 == 0) ? 2'b10 : 2'b01;
      tick(2);
    end
    tick(4);
    chk("err_sat", 32'(err), 32'd255);
    chk("err_sat_pos", 32'(pos), 32'h7);
    chk("err_sat_dir", 32'(dir), 32'h0);

    // Three forward steps landing on window cycles 3, 5 and the terminal cycle 10.
    while (cyc % 10 != 0) tick(1);
    {a, b} = 2'b00;
    tick(2);
    {a, b} = 2'b10;
    tick(5);
    {a, b} = 2'b11;
    tick(2);
    chk("spd3_pre_vld", 32'(vld), 32'h0);
    tick(1);
    chk("spd3_vld", 32'(vld), 32'h1);
    chk("spd3_val", 32'(spd), 32'd3);
    chk("spd3_pos", 32'(pos), 32'hA);
    tick(1);
    chk("spd3_vld_drop", 32'(vld), 32'h0);
    chk("spd3_hold", 32'(spd), 32'd3);
    tick(9);
    chk("spd0_vld", 32'(vld), 32'h1);
    chk("spd0_val", 32'(spd), 32'd0);

    clear_pos("clr_c");
    apply(2'b01, 4'h1, "up1");
    apply(2'b00, 4'h2, "up2");
    apply(2'b10, 4'h3, "up3");
    apply(2'b11, 4'h4, "up4");
    apply(2'b01, 4'h5, "up5");

    // Clear coincides with the step evaluated on window cycle 3.
    while (cyc % 10 != 0) tick(1);
    {a, b} = 2'b00;
    tick(2);
    chk("clr_pre", 32'(pos), 32'h5);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("clr_wins", 32'(pos), 32'h0);
    chk("clr_dir", 32'(dir), 32'h1);
    tick(1);
    chk("clr_hold", 32'(pos), 32'h0);
    tick(6);
    chk("clr_spd_vld", 32'(vld), 32'h1);
    chk("clr_spd_val", 32'(spd), 32'd1);

    tick(3);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_pos", 32'(pos), 32'h0);
    chk("mid_rst_err", 32'(err), 32'h0);
    chk("mid_rst_spd", 32'(spd), 32'h0);
    chk("mid_rst_dir", 32'(dir), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
